// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: coordinate type, ball state machine
// encoding, direction encodings and default display size.
package breakout_pkg;

  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2,
    OVER = 2'd3
  } state_e;

  // Horizontal direction: dx
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  // Vertical direction: dy
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam int D_WIDTH_DEF  = 640;
  localparam int D_HEIGHT_DEF = 480;

endpackage

// File: rtl/ball_motion_if.sv
// Ball engine bus: animation control and paddle edges in, ball
// bounding box, lives and event pulses out.
//   master : the side that drives paddle/control (paddle block, bench)
//   slave  : the ball engine
interface ball_motion_if;
  import breakout_pkg::*;

  logic       i_ani_stb;
  logic       i_animate;
  logic       i_start;
  coord_t     i_x1;
  coord_t     i_x2;
  coord_t     o_x1;
  coord_t     o_x2;
  coord_t     o_y1;
  coord_t     o_y2;
  logic [1:0] o_lives;
  logic       o_hit;
  logic       o_miss;
  logic       o_endgame;

  modport master (
    output i_ani_stb, i_animate, i_start, i_x1, i_x2,
    input  o_x1, o_x2, o_y1, o_y2, o_lives, o_hit, o_miss, o_endgame
  );

  modport slave (
    input  i_ani_stb, i_animate, i_start, i_x1, i_x2,
    output o_x1, o_x2, o_y1, o_y2, o_lives, o_hit, o_miss, o_endgame
  );

endinterface

// File: rtl/ball_collide.sv
// Purely combinational collision logic for the ball.
// Inputs : ball centre x/y, current directions dx/dy, paddle edges px1/px2.
// Outputs: next directions, paddle-hit flag, lost-ball flag.
// All comparisons are done at 13 bits with the ball half-size moved to
// the constant side so nothing can underflow.
module ball_collide
  import breakout_pkg::*;
#(
  parameter int B_SIZE   = 4,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int D_HEIGHT = D_HEIGHT_DEF,
  parameter int P_TOP    = 445
) (
  input  coord_t x,
  input  coord_t y,
  input  logic   dx,
  input  logic   dy,
  input  coord_t px1,
  input  coord_t px2,
  output logic   dx_next,
  output logic   dy_next,
  output logic   hit,
  output logic   miss
);

  // x - B <= 1        <=>  x <= B + 1
  localparam logic [12:0] LEFT_LIM  = 13'(B_SIZE + 1);
  // x + B >= W - 2    <=>  x >= W - 2 - B
  localparam logic [12:0] RIGHT_LIM = 13'(D_WIDTH - 2 - B_SIZE);
  localparam logic [12:0] TOP_LIM   = 13'(B_SIZE + 1);
  // bottom edge exactly one row above the paddle top
  localparam logic [12:0] PAD_Y     = 13'(P_TOP - 1 - B_SIZE);
  localparam logic [12:0] BOT_LIM   = 13'(D_HEIGHT - 1 - B_SIZE);

  logic [12:0] x_w;
  logic [12:0] y_w;
  logic [12:0] x_right;
  logic [12:0] px2_reach;
  logic        at_left;
  logic        at_right;
  logic        at_top;
  logic        over_paddle;
  logic        at_paddle;

  assign x_w       = {1'b0, x};
  assign y_w       = {1'b0, y};
  assign x_right   = x_w + 13'(B_SIZE);
  // x - B <= px2  <=>  x <= px2 + B
  assign px2_reach = {1'b0, px2} + 13'(B_SIZE);

  assign at_left     = (dx == DIR_LEFT)  && (x_w <= LEFT_LIM);
  assign at_right    = (dx == DIR_RIGHT) && (x_w >= RIGHT_LIM);
  assign at_top      = (dy == DIR_UP)    && (y_w <= TOP_LIM);
  assign over_paddle = (x_right >= {1'b0, px1}) && (x_w <= px2_reach);
  assign at_paddle   = (dy == DIR_DOWN) && (y_w == PAD_Y) && over_paddle;

  assign miss    = (dy == DIR_DOWN) && (y_w >= BOT_LIM);
  assign hit     = at_paddle;
  assign dx_next = at_left ? DIR_RIGHT : (at_right  ? DIR_LEFT : dx);
  assign dy_next = at_top  ? DIR_DOWN  : (at_paddle ? DIR_UP   : dy);

endmodule

// File: rtl/ball_motion.sv
// Breakout ball engine.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_ani_stb/i_animate step control, i_start launch,
//                  i_x1/i_x2 paddle edges; o_x1..o_y2 ball box,
//                  o_lives, o_hit/o_miss pulses, o_endgame.
// The ball rests on the paddle in IDLE, flies one pixel per axis per
// enabled strobe in RUN, spends one cycle in MISS after a lost ball and
// freezes in OVER once all lives are gone.
module ball_motion
  import breakout_pkg::*;
#(
  parameter int B_SIZE   = 4,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int D_HEIGHT = D_HEIGHT_DEF,
  parameter int P_TOP    = 445,
  parameter int IX       = 320,
  parameter int LIVES    = 3
) (
  input logic          i_clk,
  input logic          i_rst,
  ball_motion_if.slave bus
);

  localparam coord_t Y_REST = COORD_W'(P_TOP - B_SIZE - 1);
  localparam coord_t X_INIT = COORD_W'(IX);
  localparam coord_t B_OFF  = COORD_W'(B_SIZE);

  state_e     state_q, state_d;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       dx_q, dx_d;
  logic       dy_q, dy_d;
  logic [1:0] lives_q, lives_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;

  logic [12:0] paddle_sum;
  coord_t      paddle_mid;
  logic        step;
  logic        col_dx;
  logic        col_dy;
  logic        col_hit;
  logic        col_miss;

  // 13-bit sum so two edges near the right border cannot overflow
  assign paddle_sum = {1'b0, bus.i_x1} + {1'b0, bus.i_x2};
  assign paddle_mid = paddle_sum[12:1];
  assign step       = bus.i_ani_stb && bus.i_animate;

  ball_collide #(
    .B_SIZE   (B_SIZE),
    .D_WIDTH  (D_WIDTH),
    .D_HEIGHT (D_HEIGHT),
    .P_TOP    (P_TOP)
  ) u_collide (
    .x       (x_q),
    .y       (y_q),
    .dx      (dx_q),
    .dy      (dy_q),
    .px1     (bus.i_x1),
    .px2     (bus.i_x2),
    .dx_next (col_dx),
    .dy_next (col_dy),
    .hit     (col_hit),
    .miss    (col_miss)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    lives_d = lives_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // ball sits on top of the paddle, centred on it
        x_d = paddle_mid;
        y_d = Y_REST;
        if (bus.i_start) begin
          state_d = RUN;
          dx_d    = DIR_RIGHT;
          dy_d    = DIR_UP;
        end
      end

      RUN: begin
        if (step) begin
          if (col_miss) begin
            // ball stays where it fell out; direction is irrelevant now
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            miss_d  = 1'b1;
            state_d = MISS;
          end else begin
            dx_d  = col_dx;
            dy_d  = col_dy;
            hit_d = col_hit;
            // move with the freshly flipped directions
            x_d   = (col_dx == DIR_RIGHT) ? x_q + 12'd1 : x_q - 12'd1;
            y_d   = (col_dy == DIR_DOWN)  ? y_q + 12'd1 : y_q - 12'd1;
          end
        end
      end

      MISS: begin
        state_d = (lives_q == 2'd0) ? OVER : IDLE;
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      x_q     <= X_INIT;
      y_q     <= Y_REST;
      dx_q    <= DIR_RIGHT;
      dy_q    <= DIR_UP;
      lives_q <= 2'(LIVES);
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.o_x1      = x_q - B_OFF;
  assign bus.o_x2      = x_q + B_OFF;
  assign bus.o_y1      = y_q - B_OFF;
  assign bus.o_y2      = y_q + B_OFF;
  assign bus.o_lives   = lives_q;
  assign bus.o_hit     = hit_q;
  assign bus.o_miss    = miss_q;
  assign bus.o_endgame = (state_q == OVER);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed trajectory with
// hand-computed positions, then randomized play against a behavioural
// model of the ball until the game ends, then reset checks.
module tb_ball_motion;

  localparam int B  = 4;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int PT = 445;
  localparam int IX = 320;
  localparam int LV = 3;
  localparam int YR = PT - B - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_motion_if bus ();

  ball_motion #(
    .B_SIZE (B), .D_WIDTH (W), .D_HEIGHT (H),
    .P_TOP (PT), .IX (IX), .LIVES (LV)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    chk(name, act, exp);
    $display("check %-14s got %0d want %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 resting on paddle, 1 flying, 2 just lost, 3 game over
  int m_mode, mx, my, mvx, mvy, m_lives;
  bit m_hit, m_miss;

  always @(posedge clk) begin
    int ovx, ovy, px1, px2;
    px1 = int'(bus.i_x1);
    px2 = int'(bus.i_x2);
    if (rst) begin
      m_mode = 0; mx = IX; my = YR; mvx = 1; mvy = -1;
      m_lives = LV; m_hit = 0; m_miss = 0;
    end else begin
      m_hit = 0;
      m_miss = 0;
      case (m_mode)
        0: begin
          mx = (px1 + px2) / 2;
          my = YR;
          if (bus.i_start) begin m_mode = 1; mvx = 1; mvy = -1; end
        end
        1: if (bus.i_ani_stb && bus.i_animate) begin
          if (mvy > 0 && my + B >= H - 1) begin
            if (m_lives > 0) m_lives--;
            m_miss = 1;
            m_mode = 2;
          end else begin
            ovx = mvx; ovy = mvy;
            if (ovx < 0 && mx - B <= 1) mvx = 1;
            if (ovx > 0 && mx + B >= W - 2) mvx = -1;
            if (ovy < 0 && my - B <= 1) mvy = 1;
            if (ovy > 0 && my + B == PT - 1 && mx + B >= px1 && mx - B <= px2) begin
              mvy = -1;
              m_hit = 1;
            end
            mx += mvx;
            my += mvy;
          end
        end
        2: m_mode = (m_lives == 0) ? 3 : 0;
        default: ;
      endcase
    end
  end

  // compare process: every cycle, on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("o_x1", int'(bus.o_x1), (mx - B) & 12'hFFF);
      chk("o_x2", int'(bus.o_x2), (mx + B) & 12'hFFF);
      chk("o_y1", int'(bus.o_y1), (my - B) & 12'hFFF);
      chk("o_y2", int'(bus.o_y2), (my + B) & 12'hFFF);
      chk("o_lives", int'(bus.o_lives), m_lives);
      chk("o_hit", int'(bus.o_hit), int'(m_hit));
      chk("o_miss", int'(bus.o_miss), int'(m_miss));
      chk("o_endgame", int'(bus.o_endgame), (m_mode == 3) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic paddle(input int a, input int b);
    bus.i_x1 = 12'(a);
    bus.i_x2 = 12'(b);
  endtask

  initial begin
    int c;
    bus.i_ani_stb = 1'b0;
    bus.i_animate = 1'b0;
    bus.i_start   = 1'b0;
    paddle(100, 160);
    rst = 1'b1;
    tick(1);
    cmp_en = 1'b1;
    tick(1);
    // reset state
    lit("rst_x1", int'(bus.o_x1), 316);
    lit("rst_y2", int'(bus.o_y2), 444);
    lit("rst_lives", int'(bus.o_lives), 3);
    lit("rst_endgame", int'(bus.o_endgame), 0);
    lit("rst_hit", int'(bus.o_hit), 0);

    // IDLE tracks paddle centre
    rst = 1'b0;
    tick(1);
    lit("idle_x1", int'(bus.o_x1), 126);
    lit("idle_x2", int'(bus.o_x2), 134);
    lit("idle_y2", int'(bus.o_y2), 444);

    // launch from x=320, y=440
    paddle(290, 350);
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    paddle(60, 120);
    bus.i_ani_stb = 1'b1;
    bus.i_animate = 1'b1;
    tick(10);
    lit("fly10_x1", int'(bus.o_x1), 326);
    lit("fly10_y1", int'(bus.o_y1), 426);
    bus.i_animate = 1'b0;
    tick(5);
    lit("pause_x1", int'(bus.o_x1), 326);
    lit("pause_y1", int'(bus.o_y1), 426);

    // right wall at x=634: flips, x=633, y=125
    bus.i_animate = 1'b1;
    tick(304);
    lit("pre_wall_x2", int'(bus.o_x2), 638);
    tick(1);
    lit("rwall_x2", int'(bus.o_x2), 637);
    lit("rwall_y1", int'(bus.o_y1), 121);
    // top wall at y=5: flips, y=6, x=512
    tick(120);
    tick(1);
    lit("top_y1", int'(bus.o_y1), 2);
    lit("top_x1", int'(bus.o_x1), 508);
    // descend to y=440, x=78 over paddle 60..120
    tick(434);
    lit("pre_hit", int'(bus.o_hit), 0);
    tick(1);
    lit("hit_pulse", int'(bus.o_hit), 1);
    lit("hit_y1", int'(bus.o_y1), 435);
    lit("hit_x1", int'(bus.o_x1), 73);
    bus.i_ani_stb = 1'b0;
    tick(1);
    lit("hit_end", int'(bus.o_hit), 0);

    // randomized play until the game is over
    c = 0;
    while (c < 60000 && bus.o_endgame !== 1'b1) begin
      if (c % 64 == 0) begin
        int a;
        a = int'($urandom_range(0, 579));
        paddle(a, a + 60);
      end
      bus.i_ani_stb = ($urandom_range(0, 3) != 0);
      bus.i_animate = ($urandom_range(0, 7) != 0);
      bus.i_start   = ($urandom_range(0, 15) == 0);
      tick(1);
      c++;
    end
    $display("random phase ran %0d cycles", c);
    lit("over_endgame", int'(bus.o_endgame), 1);
    lit("over_lives", int'(bus.o_lives), 0);

    // start is ignored in OVER, ball stays frozen
    begin
      int fx, fy;
      fx = int'(bus.o_x1);
      fy = int'(bus.o_y1);
      bus.i_start = 1'b1;
      bus.i_ani_stb = 1'b1;
      bus.i_animate = 1'b1;
      tick(5);
      lit("over_hold", int'(bus.o_endgame), 1);
      lit("over_frz_x", int'(bus.o_x1), fx);
      lit("over_frz_y", int'(bus.o_y1), fy);
      bus.i_start = 1'b0;
    end

    // reset out of OVER restores lives
    rst = 1'b1;
    tick(1);
    lit("rst2_lives", int'(bus.o_lives), 3);
    lit("rst2_endgame", int'(bus.o_endgame), 0);
    lit("rst2_x1", int'(bus.o_x1), 316);

    // reset mid-flight
    rst = 1'b0;
    paddle(200, 260);
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    tick(20);
    lit("run_y1", int'(bus.o_y1), 416);
    rst = 1'b1;
    tick(1);
    lit("rst3_x1", int'(bus.o_x1), 316);
    lit("rst3_y1", int'(bus.o_y1), 436);
    lit("rst3_lives", int'(bus.o_lives), 3);
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
